ps2_rx_frame: RTL

//  Downstream of the PS/2 clock divider: samples the keyboard's ps2_clk/ps2_data lines on

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_rx_frame_if.sv | 37 +++
 rtl/ps2_sync_filter.sv | 53 +++++
 rtl/ps2_rx_frame.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame geometry and line levels.
// Used by the receive framer, the keyboard decoder and the transmitter.
package ps2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ps2_rx_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;
  // Index of the stop bit counted from the first bit after start (data 0..7, parity 8).
  localparam int unsigned LAST_BIT   = FRAME_BITS - 2;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // True when the vector carries an odd number of ones.
  function automatic logic odd_ones(input logic [DATA_BITS:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Byte handshake between the PS/2 receive framer and the keyboard decoder.
//   data_out    received byte, held until the next good frame
//   data_valid  level, high from frame completion until data_ack
//   data_ack    consumer takes data_out on any cycle with data_valid && data_ack
//   frame_error one-cycle pulse: bad stop bit, parity failure or timeout
//   overrun     one-cycle pulse: good frame completed while an unacked byte was pending
//   busy        framer is inside a frame
// master = framer side, slave = consumer side.
interface ps2_rx_frame_if;
  import ps2_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;
  logic                 frame_error;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data_out,
    output data_valid,
    input  data_ack,
    output frame_error,
    output overrun,
    output busy
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ack,
    input  frame_error,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser, sample_en-qualified glitch filter and falling-edge pulse for one
// asynchronous PS/2 line.
//   clock_in   system clock
//   reset_n    asynchronous active-low reset; line and filter reset to idle-high
//   sample_en  sampling tick; the filter only advances on it
//   pin        raw asynchronous input
//   fall       one-cycle pulse when the filtered level flips 1 -> 0
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic sample_en,
  input  logic pin,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          fall_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      fall_q <= 1'b0;
      if (sample_en) begin
        if (sync_q[1] != filt_q) begin
          // This sample is the FILTER_LEN-th consecutive one disagreeing: accept it.
          if (cnt_q >= CW'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
            fall_q <= filt_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: filters ps2_clk, deserialises 11-bit frames on its falling edges and
// presents each good byte over a valid/ack handshake.
//   clock_in   system clock
//   reset_n    asynchronous active-low reset; discards any partial frame
//   sample_en  line sampling tick from the PS/2 clock divider
//   ps2_clk    raw PS/2 clock pin
//   ps2_data   raw PS/2 data pin
//   bus        ps2_rx_frame_if.master: data_out, data_valid, data_ack, frame_error,
//              overrun, busy
// Build option: define PS2_RX_PARITY_CHECK_EN to reject frames with even data+parity ones;
// otherwise the parity bit is captured but ignored.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned TIMEOUT_TICKS = 2000
) (
  input  logic           clock_in,
  input  logic           reset_n,
  input  logic           sample_en,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_frame_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  logic                 clk_fall;
  logic [1:0]           data_sync_q;
  logic                 data_bit;
  logic                 frame_good;

  ps2_rx_state_e        state_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS:0]   shift_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 ovr_q;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .pin       (ps2_clk),
    .fall      (clk_fall)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign data_bit = data_sync_q[1];

  // Evaluated on the stop edge: shift_q then holds data (LSBs) and parity (MSB).
  always_comb begin
`ifdef PS2_RX_PARITY_CHECK_EN
    frame_good = (data_bit == STOP_BIT) && odd_ones(shift_q);
`else
    frame_good = (data_bit == STOP_BIT);
`endif
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tick_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      if (valid_q && bus.data_ack) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          tick_cnt_q <= '0;
          if (clk_fall && (data_bit == START_BIT)) begin
            state_q   <= RECV;
            bit_cnt_q <= '0;
          end
        end
        RECV: begin
          if (clk_fall) begin
            // An edge always wins over a timeout in the same cycle.
            tick_cnt_q <= '0;
            if (bit_cnt_q == 4'(LAST_BIT)) begin
              state_q <= IDLE;
              if (frame_good) begin
                data_q  <= shift_q[DATA_BITS-1:0];
                valid_q <= 1'b1;
                // An ack landing on the completion cycle consumed the old byte.
                ovr_q   <= valid_q && !bus.data_ack;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              shift_q   <= {data_bit, shift_q[DATA_BITS:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sample_en) begin
            if (tick_cnt_q >= TW'(TIMEOUT_TICKS - 1)) begin
              err_q      <= 1'b1;
              state_q    <= IDLE;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = err_q;
  assign bus.overrun     = ovr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
